register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 116 +++++++++++
 tb/tb_register_file.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Multi-ported register file with two combinational read ports and one
// synchronous write port. Register 0 is hardwired to zero: writes to address
// 0 are discarded and do not count. An 8-bit counter tracks accepted writes
// and wraps from 255 to 0.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, a read port whose address matches an in-flight accepted
//   write (We=1, Waddr!=0, Rst=0) returns Wdata in the same cycle instead of
//   the stored value. Storage, Wcount and R0 behaviour are unaffected.
//   When undefined, read ports show the stored value until the commit edge.
//
// Parameters:
//   WIDTH - data bits per register
//   DEPTH - number of registers (power of two, >= 2)
//   AW    - address bits, log2(DEPTH)
//
// Ports:
//   Clk      in   clock, all state updates on the rising edge
//   Rst      in   asynchronous active-high reset, clears storage and Wcount
//   We       in   write enable, sampled on rising Clk
//   Waddr    in   write address
//   Wdata    in   write data
//   Raddr_a  in   read port A address
//   Raddr_b  in   read port B address
//   Rdata_a  out  read port A data (combinational)
//   Rdata_b  out  read port B data (combinational)
//   Wcount   out  registered count of accepted writes (wraps)
// ---------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             We,
    input  logic [AW-1:0]    Waddr,
    input  logic [WIDTH-1:0] Wdata,
    input  logic [AW-1:0]    Raddr_a,
    input  logic [AW-1:0]    Raddr_b,
    output logic [WIDTH-1:0] Rdata_a,
    output logic [WIDTH-1:0] Rdata_b,
    output logic [7:0]       Wcount
);

    // Only R1..R(DEPTH-1) have storage; R0 is produced as a constant by the
    // read muxes, so it can never hold anything but zero.
    logic [WIDTH-1:0] regs [1:DEPTH-1];
    logic [7:0]       wcount_q;

    // A write is accepted only with We high, a non-zero address and reset
    // released. Rst also has priority in the sequential block; gating here
    // keeps the bypass path quiet during reset.
    logic wr_accept;
    assign wr_accept = We && (Waddr != '0) && !Rst;

    // Storage and write counter.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wcount_q <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_accept && (Waddr == AW'(i))) begin
                    regs[i] <= Wdata;
                end
            end
            if (wr_accept) begin
                wcount_q <= wcount_q + 8'd1;
            end
        end
    end

    assign Wcount = wcount_q;

    // Read muxes. Address 0 falls through to the zero default.
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (Raddr_a == AW'(i)) begin
                stored_a = regs[i];
            end
            if (Raddr_b == AW'(i)) begin
                stored_b = regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the pending write to any port reading the same address.
    // wr_accept already excludes address 0 and reset.
    always_comb begin
        Rdata_a = stored_a;
        Rdata_b = stored_b;
        if (wr_accept && (Raddr_a == Waddr)) begin
            Rdata_a = Wdata;
        end
        if (wr_accept && (Raddr_b == Waddr)) begin
            Rdata_b = Wdata;
        end
    end
`else
    assign Rdata_a = stored_a;
    assign Rdata_b = stored_b;
`endif

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Directed self-checking bench for register_file (WIDTH=8, DEPTH=8, AW=3).
// Inputs change on the falling clock edge; outputs are checked away from the
// rising edge. Expected values are hand-computed constants. Bypass-dependent
// expectations follow the REGFILE_BYPASS_EN macro.
// ---------------------------------------------------------------------------
module tb_register_file;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             rst;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic [7:0]       wcount;

    int check_count;
    int error_count;

    register_file #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .Clk    (clk),
        .Rst    (rst),
        .We     (we),
        .Waddr  (waddr),
        .Wdata  (wdata),
        .Raddr_a(raddr_a),
        .Raddr_b(raddr_b),
        .Rdata_a(rdata_a),
        .Rdata_b(rdata_b),
        .Wcount (wcount)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One write: inputs set on a falling edge, committed by the next rising
    // edge, We dropped on the following falling edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        @(negedge clk);
        we    = 1'b1;
        waddr = addr;
        wdata = data;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic set_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        raddr_a = a;
        raddr_b = b;
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] exp_bypass;

    initial begin
        check_count = 0;
        error_count = 0;
        rst     = 1'b1;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = '0;
        raddr_b = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        set_read(3'd3, 3'd5);
        check("reset_rdata_a", rdata_a, 8'h00);
        check("reset_rdata_b", rdata_b, 8'h00);
        check("reset_wcount", wcount, 8'd0);

        // First write right after reset release is accepted.
        rst = 1'b0;
        we    = 1'b1;
        waddr = 3'd3;
        wdata = 8'hA5;
        @(negedge clk);
        we = 1'b0;
        set_read(3'd3, 3'd3);
        check("first_write_r3", rdata_a, 8'hA5);
        check("first_write_wcount", wcount, 8'd1);

        // Asynchronous reset mid-cycle clears immediately.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_r3", rdata_a, 8'h00);
        check("async_rst_wcount", wcount, 8'd0);

        // Writes during reset are ignored; read ports stay 0.
        @(negedge clk);
        we    = 1'b1;
        waddr = 3'd6;
        wdata = 8'h5A;
        set_read(3'd6, 3'd6);
        check("rst_no_bypass_a", rdata_a, 8'h00);
        @(negedge clk);
        check("rst_write_ignored_b", rdata_b, 8'h00);
        check("rst_write_wcount", wcount, 8'd0);

        // Reset released with We already low.
        we  = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_r6", rdata_a, 8'h00);

        // Write/read on both ports.
        do_write(3'd5, 8'h3C);
        set_read(3'd5, 3'd5);
        check("wr5_port_a", rdata_a, 8'h3C);
        check("wr5_port_b", rdata_b, 8'h3C);
        check("wr5_wcount", wcount, 8'd1);
        set_read(3'd2, 3'd5);
        check("wr5_r2_untouched", rdata_a, 8'h00);

        // Zero register: write discarded, count unchanged, never bypassed.
        @(negedge clk);
        we    = 1'b1;
        waddr = 3'd0;
        wdata = 8'hFF;
        set_read(3'd0, 3'd0);
        check("r0_pre_edge", rdata_a, 8'h00);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("r0_after_write", rdata_a, 8'h00);
        check("r0_wcount", wcount, 8'd1);

        // Hold: data/address activity with We low.
        @(negedge clk);
        waddr = 3'd2;
        for (int i = 0; i < 5; i++) begin
            wdata = (i % 2 == 0) ? 8'h11 : 8'h22;
            #20;
        end
        set_read(3'd2, 3'd5);
        check("hold_r2", rdata_a, 8'h00);
        check("hold_r5", rdata_b, 8'h3C);
        check("hold_wcount", wcount, 8'd1);

        // Bypass behaviour.
        do_write(3'd4, 8'h10);
        @(negedge clk);
        we    = 1'b1;
        waddr = 3'd4;
        wdata = 8'h99;
        set_read(3'd4, 3'd5);
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 8'h99;
`else
        exp_bypass = 8'h10;
`endif
        check("bypass_pre_edge_a", rdata_a, exp_bypass);
        check("bypass_other_port_b", rdata_b, 8'h3C);
        @(posedge clk);
        #1;
        check("bypass_post_edge_a", rdata_a, 8'h99);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("bypass_wcount", wcount, 8'd3);

        // Wrap: reset, then 256 back-to-back writes to address 1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        we    = 1'b1;
        waddr = 3'd1;
        for (int i = 0; i < 256; i++) begin
            wdata = 8'(i);
            @(negedge clk);
            if (i == 254) check("wrap_wcount_255", wcount, 8'd255);
        end
        we = 1'b0;
        set_read(3'd1, 3'd4);
        check("wrap_wcount_0", wcount, 8'd0);
        check("wrap_r1_last", rdata_a, 8'hFF);
        check("wrap_r4_cleared", rdata_b, 8'h00);
        do_write(3'd1, 8'h42);
        #1;
        check("wrap_wcount_1", wcount, 8'd1);
        check("wrap_r1_new", rdata_a, 8'h42);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
